// File: rtl/pipe_stage_reg.sv
// Parameterised cascade of pipeline registers carrying {valid, ctrl, data} with stall, flush and occupancy.
// Optional bubble counter on the last stage is enabled by defining PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 4,
   parameter int unsigned STAGES = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [CTRL_W-1:0]            in_ctrl,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   output logic [CTRL_W-1:0]            out_ctrl,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(STAGES+1)-1:0]  occupancy
`ifdef PIPE_STAGE_REG_PERF_EN
   ,
   output logic [CNT_W-1:0]             bubble_cnt
`endif
);

   localparam int unsigned OCC_W = $clog2(STAGES + 1);

   // Parameter legality is checked at elaboration so bad depths never reach synthesis.
   if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("pipe_stage_reg: STAGES must be within 1..8");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_reg: CNT_W must be at least 1");
   end

   logic [STAGES-1:0]             valid_vec;
   logic [STAGES-1:0][CTRL_W-1:0] ctrl_vec;
   logic [STAGES-1:0][DATA_W-1:0] data_vec;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      logic              v_d;
      logic [CTRL_W-1:0] c_d;
      logic [DATA_W-1:0] d_d;
      logic              v_q;
      logic [CTRL_W-1:0] c_q;
      logic [DATA_W-1:0] d_q;

      // Stage 0 gates ctrl with valid; later stages inherit already-gated ctrl.
      if (g == 0) begin : g_head
         assign v_d = in_valid;
         assign c_d = in_valid ? in_ctrl : '0;
         assign d_d = in_data;
      end else begin : g_body
         assign v_d = valid_vec[g-1];
         assign c_d = ctrl_vec[g-1];
         assign d_d = data_vec[g-1];
      end

      // Flush kills valid/ctrl but leaves data in place; it outranks stall.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= '0;
            d_q <= '0;
         end else if (flush) begin
            v_q <= 1'b0;
            c_q <= '0;
         end else if (!stall) begin
            v_q <= v_d;
            c_q <= c_d;
            d_q <= d_d;
         end
      end

      assign valid_vec[g] = v_q;
      assign ctrl_vec[g]  = c_q;
      assign data_vec[g]  = d_q;
   end

   assign out_valid = valid_vec[STAGES-1];
   assign out_ctrl  = ctrl_vec[STAGES-1];
   assign out_data  = data_vec[STAGES-1];

   assign occupancy = OCC_W'($countones(valid_vec));

`ifdef PIPE_STAGE_REG_PERF_EN
   // Counts edges where the last stage held no instruction; saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (!valid_vec[STAGES-1] && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg at depths 3 and 2, against a queue-based model.
// Bubble counter checks are active when PIPE_STAGE_REG_PERF_EN is defined.
module tb_pipe_stage_reg;

   typedef struct {
      logic        v;
      logic [3:0]  c;
      logic [31:0] d;
   } ent_t;
   typedef ent_t ent_q_t[$];

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [3:0]  in_ctrl;
   logic [31:0] in_data;

   logic        v3, v2;
   logic [3:0]  c3, c2;
   logic [31:0] d3, d2;
   logic [1:0]  o3, o2;
`ifdef PIPE_STAGE_REG_PERF_EN
   logic [3:0]  bub3, bub2;
`endif

   int vectors = 0;
   int errors  = 0;
   bit check_en = 1'b0;

   ent_q_t m3, m2;
   int     b3 = 0;
   int     b2 = 0;

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .STAGES(3), .CNT_W(4)) u3 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(v3), .out_ctrl(c3), .out_data(d3), .occupancy(o3)
`ifdef PIPE_STAGE_REG_PERF_EN
      , .bubble_cnt(bub3)
`endif
   );

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .STAGES(2), .CNT_W(4)) u2 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(v2), .out_ctrl(c2), .out_data(d2), .occupancy(o2)
`ifdef PIPE_STAGE_REG_PERF_EN
      , .bubble_cnt(bub2)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic ent_q_t blank(int depth);
      ent_q_t r;
      ent_t   e;
      e.v = 1'b0;
      e.c = 4'h0;
      e.d = 32'h0;
      for (int i = 0; i < depth; i++) r.push_back(e);
      return r;
   endfunction

   // Queue front is the oldest entry, i.e. what the last stage presents.
   function automatic ent_q_t advance(ent_q_t q, logic stl, logic fl, ent_t nw);
      ent_q_t r;
      ent_t   e;
      r = q;
      e = nw;
      if (fl) begin
         foreach (r[i]) begin
            r[i].v = 1'b0;
            r[i].c = 4'h0;
         end
      end else if (!stl) begin
         void'(r.pop_front());
         if (!e.v) e.c = 4'h0;
         r.push_back(e);
      end
      return r;
   endfunction

   function automatic int occ(ent_q_t q);
      int n = 0;
      foreach (q[i]) if (q[i].v) n++;
      return n;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      ent_t nw;
      if (!rst_n) begin
         m3 = blank(3);
         m2 = blank(2);
         b3 = 0;
         b2 = 0;
      end else begin
         if (!m3[0].v && b3 < 15) b3++;
         if (!m2[0].v && b2 < 15) b2++;
         nw.v = in_valid;
         nw.c = in_ctrl;
         nw.d = in_data;
         m3 = advance(m3, stall, flush, nw);
         m2 = advance(m2, stall, flush, nw);
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("u3_valid", 64'(v3), 64'(m3[0].v));
         chk("u3_ctrl",  64'(c3), 64'(m3[0].c));
         chk("u3_data",  64'(d3), 64'(m3[0].d));
         chk("u3_occ",   64'(o3), 64'(occ(m3)));
         chk("u2_valid", 64'(v2), 64'(m2[0].v));
         chk("u2_ctrl",  64'(c2), 64'(m2[0].c));
         chk("u2_data",  64'(d2), 64'(m2[0].d));
         chk("u2_occ",   64'(o2), 64'(occ(m2)));
`ifdef PIPE_STAGE_REG_PERF_EN
         chk("u3_bubble", 64'(bub3), 64'(b3));
         chk("u2_bubble", 64'(bub2), 64'(b2));
`endif
      end
   end

   // Caller sits on a negedge; inputs change 1 time unit later, then one full cycle passes.
   task automatic cyc(logic v, logic [3:0] c, logic [31:0] d, logic st, logic fl);
      #1;
      in_valid = v;
      in_ctrl  = c;
      in_data  = d;
      stall    = st;
      flush    = fl;
      @(negedge clk);
   endtask

   initial begin
      m3 = blank(3);
      m2 = blank(2);
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in_ctrl = 4'h0;
      in_data = 32'h0;
      @(negedge clk);
      @(negedge clk);
      check_en = 1'b1;
      chk("reset_valid", 64'(v3), 64'(0));
      chk("reset_data",  64'(d3), 64'(0));
      chk("reset_occ",   64'(o3), 64'(0));
      #1 rst_n = 1'b1;
      @(negedge clk);

      // Single valid entry emerges exactly 3 edges later, for one cycle.
      cyc(1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
      chk("lat_e1", 64'(v3), 64'(0));
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      chk("lat_e2", 64'(v3), 64'(0));
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      chk("lat_e3_valid", 64'(v3), 64'(1));
      chk("lat_e3_ctrl",  64'(c3), 64'(4'hF));
      chk("lat_e3_data",  64'(d3), 64'(32'hDEADBEEF));
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      chk("lat_e4", 64'(v3), 64'(0));

      // Bubble with ctrl asserted at the input must leave with ctrl cleared.
      repeat (3) cyc(1'b0, 4'hF, 32'h1234, 1'b0, 1'b0);
      chk("bub_valid", 64'(v3), 64'(0));
      chk("bub_ctrl",  64'(c3), 64'(0));
      chk("bub_data",  64'(d3), 64'(32'h1234));

      // Stall freezes a full depth-2 pipe.
      cyc(1'b1, 4'h1, 32'hAAAA0001, 1'b0, 1'b0);
      cyc(1'b1, 4'h2, 32'hBBBB0002, 1'b0, 1'b0);
      chk("stall_pre_occ", 64'(o2), 64'(2));
      for (int i = 0; i < 4; i++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'b1, 1'b0);
         chk("stall_data", 64'(d2), 64'(32'hAAAA0001));
         chk("stall_occ",  64'(o2), 64'(2));
      end
      cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      chk("stall_rel_valid", 64'(v2), 64'(1));
      chk("stall_rel_ctrl",  64'(c2), 64'(4'h2));
      chk("stall_rel_data",  64'(d2), 64'(32'hBBBB0002));

      // Flush beats stall; data is held.
      cyc(1'b1, 4'h3, 32'hCCCC0003, 1'b0, 1'b0);
      cyc(1'b1, 4'h5, 32'hDDDD0005, 1'b0, 1'b0);
      chk("flush_pre_occ", 64'(o2), 64'(2));
      cyc(1'b1, 4'h7, 32'hEEEE0007, 1'b1, 1'b1);
      chk("flush_occ",   64'(o2), 64'(0));
      chk("flush_valid", 64'(v2), 64'(0));
      chk("flush_ctrl",  64'(c2), 64'(0));
      chk("flush_data",  64'(d2), 64'(32'hCCCC0003));

      // Asynchronous reset between edges clears outputs immediately.
      repeat (3) cyc(1'b1, 4'h9, 32'h11110009, 1'b0, 1'b0);
      chk("areset_pre_occ", 64'(o3), 64'(3));
      #2 rst_n = 1'b0;
      #1;
      chk("areset_valid", 64'(v3), 64'(0));
      chk("areset_ctrl",  64'(c3), 64'(0));
      chk("areset_data",  64'(d3), 64'(0));
      chk("areset_occ",   64'(o3), 64'(0));
      chk("areset_occ2",  64'(o2), 64'(0));
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("resume_occ", 64'(o3), 64'(1));

      // Idle after reset saturates the 4-bit bubble counter.
      #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      repeat (19) cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_REG_PERF_EN
      chk("bubble_sat", 64'(bub3), 64'(15));
`endif
      repeat (3) cyc(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_REG_PERF_EN
      chk("bubble_hold", 64'(bub3), 64'(15));
`endif
      chk("idle_occ", 64'(o3), 64'(0));

      // Random traffic with occasional stall, flush and reset.
      for (int n = 0; n < 3000; n++) begin
         #1;
         rst_n    = ($urandom_range(0, 199) != 0);
         in_valid = 1'($urandom_range(0, 1));
         in_ctrl  = 4'($urandom);
         in_data  = $urandom;
         stall    = ($urandom_range(0, 4) == 0);
         flush    = ($urandom_range(0, 19) == 0);
         @(negedge clk);
      end

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
